// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// Holds default geometry, the op encoding and the stage-count helper.
package adder_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultChunk = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned adder_stages(input int unsigned width,
                                               input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational CHUNK-bit adder slice: sum, carry-out and the carry into its top bit.
// The top-bit carry lets the final slice derive signed overflow.
module add_slice
  import adder_pkg::*;
#(
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] full;

  assign full     = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s        = full[CHUNK-1:0];
  assign cout     = full[CHUNK];
  // Carry into the top bit is recovered from that bit's sum equation.
  assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/adder_pipe_param.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage, valid/ready on both sides.
// Registered outputs; in_ready depends combinationally on out_ready.
module adder_pipe_param
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES    = adder_stages(WIDTH, CHUNK);
  localparam int unsigned ChunkSafe = (CHUNK < 1) ? 1 : CHUNK;

  if ((CHUNK < 1) || (WIDTH < ChunkSafe) || ((WIDTH % ChunkSafe) != 0)) begin : g_param_check
    $fatal(1, "adder_pipe_param: WIDTH must be a non-zero multiple of CHUNK (CHUNK >= 1)");
  end

  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic              adv;
  logic              ovf_q;
  logic [STAGES-1:0] vld_q, carry_q;
  logic [STAGES-1:0] st_vld, st_cin, sl_cout, sl_cmsb;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  st_a [STAGES];
  logic [WIDTH-1:0]  st_b [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [CHUNK-1:0]  sl_s [STAGES];

  assign b_eff     = (sub == OP_ADD) ? b : ~b;
  assign c0        = (sub == OP_SUB) ? ~cin : cin;
  assign adv       = ~vld_q[STAGES-1] | out_ready;
  assign in_ready  = adv & ~rst;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

  // Whole operand words travel down the pipe; stage k only reads slice k, so the
  // already-consumed low bits and the final stage's copy are never observed.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign st_vld[k] = in_valid;
      assign st_a[k]   = a;
      assign st_b[k]   = b_eff;
      assign st_sum[k] = '0;
      assign st_cin[k] = c0;
    end else begin : g_body
      assign st_vld[k] = vld_q[k-1];
      assign st_a[k]   = a_q[k-1];
      assign st_b[k]   = b_q[k-1];
      assign st_sum[k] = sum_q[k-1];
      assign st_cin[k] = carry_q[k-1];
    end

    add_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .a       (st_a[k][k*CHUNK +: CHUNK]),
      .b       (st_b[k][k*CHUNK +: CHUNK]),
      .cin     (st_cin[k]),
      .s       (sl_s[k]),
      .cout    (sl_cout[k]),
      .c_msb_in(sl_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]                   = st_sum[k];
      sum_d[k][k*CHUNK +: CHUNK] = sl_s[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= st_vld;
      // Data registers only load behind a valid entry, so bubbles leave them untouched.
      for (int k = 0; k < STAGES; k++) begin
        if (st_vld[k]) begin
          a_q[k]     <= st_a[k];
          b_q[k]     <= st_b[k];
          sum_q[k]   <= sum_d[k];
          carry_q[k] <= sl_cout[k];
        end
      end
      if (st_vld[STAGES-1]) begin
        ovf_q <= sl_cout[STAGES-1] ^ sl_cmsb[STAGES-1];
      end
    end
  end

  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], sl_cmsb};

endmodule

// File: tb/tb_adder_pipe_param.sv
// Directed bench for adder_pipe_param: three geometries (8/4, 16/4, 4/4) share stimulus buses.
// sel picks which instance receives in_valid and whose outputs are observed.
module tb_adder_pipe_param;

  logic        clk = 1'b0;
  logic        rst, iv, ordy;
  int          sel;
  logic [15:0] ta, tb;
  logic        tcin, tsub;
  int          errors = 0;
  int          checks = 0;

  logic       rdy8, ov8, co8, of8;
  logic [7:0] s8;
  logic        rdy16, ov16, co16, of16;
  logic [15:0] s16;
  logic       rdy4, ov4, co4, of4;
  logic [3:0] s4;

  logic        obs_ready, obs_valid, obs_cout, obs_ovf;
  logic [15:0] obs_sum;

  always #5 clk = ~clk;

  adder_pipe_param #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv && (sel == 0)), .in_ready(rdy8),
    .a(ta[7:0]), .b(tb[7:0]), .cin(tcin), .sub(tsub),
    .out_valid(ov8), .out_ready(ordy), .sum(s8), .cout(co8), .ovf(of8)
  );

  adder_pipe_param #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv && (sel == 1)), .in_ready(rdy16),
    .a(ta), .b(tb), .cin(tcin), .sub(tsub),
    .out_valid(ov16), .out_ready(ordy), .sum(s16), .cout(co16), .ovf(of16)
  );

  adder_pipe_param #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv && (sel == 2)), .in_ready(rdy4),
    .a(ta[3:0]), .b(tb[3:0]), .cin(tcin), .sub(tsub),
    .out_valid(ov4), .out_ready(ordy), .sum(s4), .cout(co4), .ovf(of4)
  );

  always_comb begin
    obs_ready = rdy8;
    obs_valid = ov8;
    obs_sum   = {8'h00, s8};
    obs_cout  = co8;
    obs_ovf   = of8;
    case (sel)
      1: begin
        obs_ready = rdy16; obs_valid = ov16; obs_sum = s16; obs_cout = co16; obs_ovf = of16;
      end
      2: begin
        obs_ready = rdy4; obs_valid = ov4; obs_sum = {12'h000, s4}; obs_cout = co4;
        obs_ovf = of4;
      end
      default: begin end
    endcase
  end

  // 16-bit reference: {ovf, cout, sum}; cout is "no borrow" for subtract.
  function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
    logic [16:0] full;
    logic        co, ov;
    if (!s) full = {1'b0, x} + {1'b0, y} + {16'h0000, c};
    else    full = {1'b0, x} - {1'b0, y} - {16'h0000, c};
    co = s ? ~full[16] : full[16];
    if (!s) ov = (x[15] == y[15]) && (full[15] != x[15]);
    else    ov = (x[15] != y[15]) && (full[15] != x[15]);
    return {ov, co, full[15:0]};
  endfunction

  // Issues one operation on the selected instance and waits (bounded) for its result.
  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                       input logic os, output logic [15:0] rs, output logic rc,
                       output logic ro, output int lat);
    ta = oa; tb = ob; tcin = oc; tsub = os; iv = 1'b1;
    @(negedge clk);
    iv  = 1'b0;
    lat = 1;
    while (!obs_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rs = obs_sum; rc = obs_cout; ro = obs_ovf;
  endtask

  task automatic test_reset();
    sel = 0; iv = 1'b1; rst = 1'b1; ta = 16'h00AA; tb = 16'h0055;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (obs_ready !== 1'b0) begin errors++;
        $display("FAIL reset in_ready[%0d]: got %b want 0", i, obs_ready); end
      checks++; if (obs_valid !== 1'b0) begin errors++;
        $display("FAIL reset out_valid[%0d]: got %b want 0", i, obs_valid); end
      checks++; if (obs_sum !== 16'h0000) begin errors++;
        $display("FAIL reset sum[%0d]: got %h want 00", i, obs_sum); end
      checks++; if (obs_cout !== 1'b0) begin errors++;
        $display("FAIL reset cout[%0d]: got %b want 0", i, obs_cout); end
      checks++; if (obs_ovf !== 1'b0) begin errors++;
        $display("FAIL reset ovf[%0d]: got %b want 0", i, obs_ovf); end
    end
    rst = 1'b0; iv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (obs_valid !== 1'b0) begin errors++;
        $display("FAIL post_reset out_valid[%0d]: got %b want 0", i, obs_valid); end
    end
  endtask

  task automatic test_add();
    logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h0C};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h0D};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'h00, 8'h80, 8'h1A};
    logic       ec [3] = '{1'b1, 1'b0, 1'b0};
    logic       eo [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] rs; logic rc, ro; int lat;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      do_op({8'h00, va[i]}, {8'h00, vb[i]}, vc[i], 1'b0, rs, rc, ro, lat);
      checks++; if (rs !== {8'h00, es[i]}) begin errors++;
        $display("FAIL add[%0d] sum: got %h want %h", i, rs, es[i]); end
      checks++; if (rc !== ec[i]) begin errors++;
        $display("FAIL add[%0d] cout: got %b want %b", i, rc, ec[i]); end
      checks++; if (ro !== eo[i]) begin errors++;
        $display("FAIL add[%0d] ovf: got %b want %b", i, ro, eo[i]); end
      checks++; if (lat != 2) begin errors++;
        $display("FAIL add[%0d] latency: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_sub();
    logic [7:0] va [3] = '{8'h05, 8'h80, 8'h10};
    logic [7:0] vb [3] = '{8'h07, 8'h01, 8'h01};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'hFE, 8'h7F, 8'h0E};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    logic       eo [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] rs; logic rc, ro; int lat;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      do_op({8'h00, va[i]}, {8'h00, vb[i]}, vc[i], 1'b1, rs, rc, ro, lat);
      checks++; if (rs !== {8'h00, es[i]}) begin errors++;
        $display("FAIL sub[%0d] sum: got %h want %h", i, rs, es[i]); end
      checks++; if (rc !== ec[i]) begin errors++;
        $display("FAIL sub[%0d] cout: got %b want %b", i, rc, ec[i]); end
      checks++; if (ro !== eo[i]) begin errors++;
        $display("FAIL sub[%0d] ovf: got %b want %b", i, ro, eo[i]); end
      checks++; if (lat != 2) begin errors++;
        $display("FAIL sub[%0d] latency: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_q [$];
    logic [17:0] e;
    int sent = 0, got = 0, cyc = 0, first = -1, gaps = 0;
    sel = 1; ordy = 1'b1;
    ta = 16'($urandom); tb = 16'($urandom); tcin = 1'($urandom); tsub = 1'($urandom);
    iv = 1'b1;
    exp_q.push_back(ref_model(ta, tb, tcin, tsub));
    sent = 1;
    while (got < 32 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (obs_valid) begin
        if (first < 0) first = cyc;
        else if (cyc != first + got) gaps++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream extra result: got %h want none", obs_sum);
        end else begin
          e = exp_q.pop_front();
          if ({obs_ovf, obs_cout, obs_sum} !== e) begin
            errors++;
            $display("FAIL stream[%0d]: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                     got, obs_ovf, obs_cout, obs_sum, e[17], e[16], e[15:0]);
          end
        end
        got++;
      end
      if (sent < 32) begin
        checks++; if (obs_ready !== 1'b1) begin errors++;
          $display("FAIL stream in_ready[%0d]: got %b want 1", sent, obs_ready); end
        ta = 16'($urandom); tb = 16'($urandom); tcin = 1'($urandom); tsub = 1'($urandom);
        exp_q.push_back(ref_model(ta, tb, tcin, tsub));
        sent++;
      end else begin
        iv = 1'b0;
      end
    end
    iv = 1'b0;
    checks++; if (first != 4) begin errors++;
      $display("FAIL stream first_cycle: got %0d want 4", first); end
    checks++; if (gaps != 0) begin errors++;
      $display("FAIL stream gaps: got %0d want 0", gaps); end
    checks++; if (got != 32) begin errors++;
      $display("FAIL stream count: got %0d want 32", got); end
  endtask

  task automatic test_degenerate();
    logic [15:0] rs; logic rc, ro; int lat;
    sel = 2;
    do_op(16'h000C, 16'h000D, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++; if (rs !== 16'h0009) begin errors++;
      $display("FAIL w4 sum: got %h want 9", rs); end
    checks++; if (rc !== 1'b1) begin errors++;
      $display("FAIL w4 cout: got %b want 1", rc); end
    checks++; if (ro !== 1'b0) begin errors++;
      $display("FAIL w4 ovf: got %b want 0", ro); end
    checks++; if (lat != 1) begin errors++;
      $display("FAIL w4 latency: got %0d want 1", lat); end
  endtask

  task automatic test_backpressure();
    logic [7:0] es [3] = '{8'h33, 8'h10, 8'h20};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] rs [3];
    logic       rc [3];
    int cnt = 0;
    sel = 0; ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    ta = 16'h0011; tb = 16'h0022; tcin = 1'b0; tsub = 1'b0; iv = 1'b1;
    @(negedge clk);
    ta = 16'h00F0; tb = 16'h0020;
    @(negedge clk);
    ta = 16'h0050; tb = 16'h0030; tsub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (obs_ready !== 1'b0) begin errors++;
        $display("FAIL stall in_ready[%0d]: got %b want 0", i, obs_ready); end
      checks++; if (obs_valid !== 1'b1) begin errors++;
        $display("FAIL stall out_valid[%0d]: got %b want 1", i, obs_valid); end
      checks++; if (obs_sum !== 16'h0033) begin errors++;
        $display("FAIL stall sum[%0d]: got %h want 33", i, obs_sum); end
      @(negedge clk);
    end
    ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (obs_valid) begin
        if (cnt < 3) begin rs[cnt] = obs_sum[7:0]; rc[cnt] = obs_cout; end
        cnt++;
      end
      @(negedge clk);
      iv = 1'b0;
    end
    checks++; if (cnt != 3) begin errors++;
      $display("FAIL drain count: got %0d want 3", cnt); end
    for (int i = 0; i < 3; i++) begin
      if (i < cnt) begin
        checks++; if (rs[i] !== es[i] || rc[i] !== ec[i]) begin errors++;
          $display("FAIL drain[%0d]: got sum=%h cout=%b want sum=%h cout=%b",
                   i, rs[i], rc[i], es[i], ec[i]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] rs; logic rc, ro; int lat; int seen = 0;
    sel = 1; ordy = 1'b1; tcin = 1'b0; tsub = 1'b0;
    @(negedge clk);
    ta = 16'h1234; tb = 16'h1111; iv = 1'b1;
    @(negedge clk);
    ta = 16'h0F0F; tb = 16'h0101;
    @(negedge clk);
    iv = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (obs_valid !== 1'b0) begin errors++;
      $display("FAIL midreset out_valid: got %b want 0", obs_valid); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (obs_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++;
      $display("FAIL midreset stale results: got %0d want 0", seen); end
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++; if (rs !== 16'h5555 || rc !== 1'b0 || ro !== 1'b0) begin errors++;
      $display("FAIL midreset new op: got sum=%h cout=%b ovf=%b want sum=5555 cout=0 ovf=0",
               rs, rc, ro); end
    checks++; if (lat != 4) begin errors++;
      $display("FAIL midreset latency: got %0d want 4", lat); end
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; ordy = 1'b1; sel = 0;
    ta = '0; tb = '0; tcin = 1'b0; tsub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_degenerate();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/adder_pipe_param.md
Name: adder_pipe_param

Overview:
Parametrised, pipelined add/subtract unit; successor to the fixed 4-bit combinational adder. Splits a WIDTH-bit operation into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. Uses a valid/ready handshake on both sides, so it can sit directly in the datapath between a producer and a consumer that may stall. Accepts one operation per cycle at full throughput.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits summed per pipeline stage; STAGES = WIDTH/CHUNK, and STAGES is at least 1.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands present this cycle.
in_ready  output  1  unit accepts operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in for add; borrow-in for subtract.
sub  input  1  0 = A+B+cin; 1 = A-B-cin.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry out of the MSB (for subtract, 1 = no borrow).
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst=1 at a clock edge): every stage valid bit clears. sum, cout and ovf all go to 0, and every internal data/carry register goes to 0. out_valid is 0 from the first edge with rst high. Reset is honoured mid-operation: all in-flight operations are discarded and none emerge afterwards. in_ready is 0 while rst=1.
- Operand conditioning at acceptance: b_eff = sub ? ~b : b, and c0 = sub ? ~cin : cin. Stage k (k = 0..STAGES-1) computes slice k of a + b_eff + carry_k, where carry_0 = c0 and carry_k+1 is stage k's registered carry-out.
- Skew: operand slices for stage k are delayed k cycles. Result slices are de-skewed so that all WIDTH bits of sum, cout and ovf for one operation present together.
- cout is the carry out of bit WIDTH-1. ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Advance: adv = ~out_valid | out_ready. When adv=1, every stage shifts forward by one and in_ready = adv.
- An operation is accepted when in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- When adv=0, the whole pipeline holds. sum, cout, ovf and out_valid stay stable, and no operation is lost or duplicated.
- Latency: an operation accepted at edge N presents out_valid=1 after edge N+STAGES, given no stall. With STAGES=1 the result is simply registered (latency 1).
- Throughput: 1 operation/cycle with out_ready held at 1. Results leave in acceptance order.
- Outputs are registered; no combinational path runs from a/b to sum. in_ready depends combinationally on out_ready (documented; the consumer must not make out_ready depend on in_valid).
- Elaboration check: WIDTH % CHUNK != 0 or CHUNK < 1 is a fatal elaboration error.

Decomposition:
- Shared package adder_pkg: default WIDTH/CHUNK constants, a function returning STAGES, and an op-encoding constant (OP_ADD = 0, OP_SUB = 1).
- One sub-module, add_slice: combinational CHUNK-bit adder with inputs a, b and cin, and outputs s, cout and c_msb_in (the carry into its top bit, used for ovf on the final slice).
- The top level generates STAGES add_slice instances plus the skew/de-skew register arrays and the valid chain.

Test Plan:
1. Reset with WIDTH=8, CHUNK=4: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, sum=0x00, cout=0, ovf=0 throughout, and no output appears afterwards.
2. Add, WIDTH=8 CHUNK=4:
   - 0xFF+0x01, cin=0 -> 2 cycles later sum=0x00, cout=1, ovf=0.
   - 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
   - 0x0C+0x0D, cin=1 -> sum=0x1A, cout=0, ovf=0.
3. Subtract, WIDTH=8 CHUNK=4:
   - 0x05-0x07, cin=0 -> sum=0xFE, cout=0, ovf=0.
   - 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
   - 0x10-0x01, cin=1 -> sum=0x0E, cout=1.
4. Streaming and degenerate case:
   - 32 random back-to-back operations with out_ready=1, WIDTH=16 CHUNK=4 -> first result at cycle 4, then one per cycle, in order, all matching the reference model.
   - WIDTH=4 CHUNK=4: 0xC+0xD -> sum=0x9, cout=1, latency 1.
5. Backpressure: pipeline full, out_ready=0 for 5 cycles -> in_ready=0, outputs frozen. Release out_ready -> all queued results drain in order, with no loss or duplication.
6. Reset mid-flight: two operations in flight, rst pulsed 1 cycle -> out_valid=0 on the next edge, and neither operation emerges. A new operation accepted after reset returns a correct result with normal latency.
